// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: decoded instruction codes,
// sequencer state encoding and address-path widths.
package mips_pkg;

  localparam int unsigned CODE_W   = 7;
  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned INDEX_W  = 26;

  typedef enum logic [CODE_W-1:0] {
    IC_NOP    = 7'd0,
    IC_ADDU   = 7'd1,
    IC_SUBU   = 7'd2,
    IC_BEQ    = 7'd30,
    IC_BGEZ   = 7'd31,
    IC_BGEZAL = 7'd32,
    IC_BGTZ   = 7'd33,
    IC_BLEZ   = 7'd34,
    IC_BLTZ   = 7'd35,
    IC_BLTZAL = 7'd36,
    IC_BNE    = 7'd37,
    IC_J      = 7'd38,
    IC_JAL    = 7'd39,
    IC_JALR   = 7'd40,
    IC_JR     = 7'd41
  } internal_code_e;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/pc_sequencer_if.sv
// Retire-side bus between the control FSM (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CODE_W = 7
);
  logic              retire;
  logic [CODE_W-1:0] internal_code;
  logic [15:0]       offset;
  logic [25:0]       instr_index;
  logic [ADDR_W-1:0] reg_target;
  logic              zero;
  logic              positive;
  logic              negative;
  logic [ADDR_W-1:0] pc;
  logic              link_we;
  logic [ADDR_W-1:0] link_addr;
  logic              halted;
  logic              addr_error;

  modport master (
    output retire, internal_code, offset, instr_index, reg_target,
           zero, positive, negative,
    input  pc, link_we, link_addr, halted, addr_error
  );

  modport slave (
    input  retire, internal_code, offset, instr_index, reg_target,
           zero, positive, negative,
    output pc, link_we, link_addr, halted, addr_error
  );
endinterface

// File: rtl/pc_sequencer_branch_resolve.sv
// Combinational branch/jump decode: taken condition, target address,
// link-write request and misaligned register-jump detection.
module branch_resolve
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CODE_W = 7
) (
  input  logic [CODE_W-1:0] code_i,
  input  logic              zero_i,
  input  logic              positive_i,
  input  logic              negative_i,
  input  logic [15:0]       offset_i,
  input  logic [25:0]       instr_index_i,
  input  logic [ADDR_W-1:0] reg_target_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic              taken_o,
  output logic [ADDR_W-1:0] target_o,
  output logic              link_we_o,
  output logic              misaligned_o
);

  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] j_target;
  logic              is_reg_jump;

  assign pc_plus4  = pc_i + ADDR_W'(4);
  assign br_target = pc_plus4 + ADDR_W'({{(ADDR_W-18){offset_i[15]}}, offset_i, 2'b00});
  // Upper bits above bit 27 come from the delay-slot address; lower 28 from the index.
  assign j_target  = (pc_plus4 & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'({instr_index_i, 2'b00});

  assign is_reg_jump  = (code_i == CODE_W'(IC_JR)) || (code_i == CODE_W'(IC_JALR));
  assign misaligned_o = is_reg_jump && (reg_target_i[1:0] != 2'b00);

  always_comb begin
    taken_o   = 1'b0;
    target_o  = br_target;
    link_we_o = 1'b0;
    case (code_i)
      CODE_W'(IC_BEQ):    taken_o = zero_i;
      CODE_W'(IC_BNE):    taken_o = !zero_i;
      CODE_W'(IC_BGTZ):   taken_o = positive_i;
      CODE_W'(IC_BLEZ):   taken_o = zero_i | negative_i;
      CODE_W'(IC_BGEZ):   taken_o = zero_i | positive_i;
      CODE_W'(IC_BLTZ):   taken_o = negative_i;
      CODE_W'(IC_BGEZAL): begin
        taken_o   = zero_i | positive_i;
        link_we_o = 1'b1;
      end
      CODE_W'(IC_BLTZAL): begin
        taken_o   = negative_i;
        link_we_o = 1'b1;
      end
      CODE_W'(IC_J): begin
        taken_o  = 1'b1;
        target_o = j_target;
      end
      CODE_W'(IC_JAL): begin
        taken_o   = 1'b1;
        target_o  = j_target;
        link_we_o = 1'b1;
      end
      CODE_W'(IC_JR): begin
        taken_o  = !misaligned_o;
        target_o = reg_target_i;
      end
      CODE_W'(IC_JALR): begin
        taken_o   = !misaligned_o;
        target_o  = reg_target_i;
        link_we_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Architectural PC register with one-instruction delay slot, link address
// generation and halt detection for the multicycle MIPS core.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned     ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 32'hBFC0_0000,
  parameter logic [ADDR_W-1:0] HALT_ADDR    = 32'h0000_0000,
  parameter int unsigned     CODE_W       = 7
) (
  input  logic               clk,
  input  logic               reset,
  pc_sequencer_if.slave      bus
);

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] target_q, target_d;
  logic              delay_pending_q, delay_pending_d;
  logic              addr_error_q, addr_error_d;

  logic              taken;
  logic [ADDR_W-1:0] target;
  logic              misaligned;

  branch_resolve #(
    .ADDR_W (ADDR_W),
    .CODE_W (CODE_W)
  ) u_branch_resolve (
    .code_i        (bus.internal_code),
    .zero_i        (bus.zero),
    .positive_i    (bus.positive),
    .negative_i    (bus.negative),
    .offset_i      (bus.offset),
    .instr_index_i (bus.instr_index),
    .reg_target_i  (bus.reg_target),
    .pc_i          (pc_q),
    .taken_o       (taken),
    .target_o      (target),
    .link_we_o     (bus.link_we),
    .misaligned_o  (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= ST_RUN;
      pc_q            <= RESET_VECTOR;
      target_q        <= '0;
      delay_pending_q <= 1'b0;
      addr_error_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      target_q        <= target_d;
      delay_pending_q <= delay_pending_d;
      addr_error_q    <= addr_error_d;
    end
  end

  // Next-state: only a retire in RUN moves anything; a second taken branch
  // inside the delay slot is dropped so the first target wins.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    target_d        = target_q;
    delay_pending_d = delay_pending_q;
    addr_error_d    = addr_error_q;
    if ((state_q == ST_RUN) && bus.retire) begin
      pc_d = delay_pending_q ? target_q : (pc_q + ADDR_W'(4));
      if (taken && !delay_pending_q) begin
        target_d        = target;
        delay_pending_d = 1'b1;
      end else begin
        delay_pending_d = 1'b0;
      end
      if (misaligned) begin
        addr_error_d = 1'b1;
      end
      if (pc_d == HALT_ADDR) begin
        state_d = ST_HALTED;
      end
    end
  end

  assign bus.pc         = pc_q;
  assign bus.link_addr  = pc_q + ADDR_W'(8);
  assign bus.halted     = (state_q == ST_HALTED);
  assign bus.addr_error = addr_error_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, branches, jumps, delay
// slot, misaligned register jumps, reset mid-slot and halt.
module tb_pc_sequencer;
  import mips_pkg::*;

  localparam int unsigned ADDR_W = 32;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  pc_sequencer_if #(.ADDR_W(ADDR_W), .CODE_W(CODE_W)) bus ();

  pc_sequencer #(
    .ADDR_W       (ADDR_W),
    .RESET_VECTOR (32'hBFC0_0000),
    .HALT_ADDR    (32'h0000_0000),
    .CODE_W       (CODE_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic set_op(input internal_code_e code, input logic z, input logic [15:0] off,
                        input logic [25:0] idx, input logic [31:0] rt);
    bus.internal_code = CODE_W'(code);
    bus.zero          = z;
    bus.positive      = 1'b0;
    bus.negative      = 1'b0;
    bus.offset        = off;
    bus.instr_index   = idx;
    bus.reg_target    = rt;
  endtask

  task automatic do_retire();
    bus.retire = 1'b1;
    @(posedge clk);
    #1;
    bus.retire = 1'b0;
    set_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
  endtask

  task automatic retire_op(input internal_code_e code, input logic z, input logic [15:0] off,
                           input logic [25:0] idx, input logic [31:0] rt);
    set_op(code, z, off, idx, rt);
    do_retire();
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    bus.retire = 1'b0;
    set_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    chk("reset_pc", bus.pc, 32'hBFC0_0000);
    chk("reset_halted", 32'(bus.halted), 32'h0);
    chk("reset_addr_error", 32'(bus.addr_error), 32'h0);
    chk("addu_link_we", 32'(bus.link_we), 32'h0);

    // Sequential flow and hold without retire
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("seq_pc1", bus.pc, 32'hBFC0_0004);
    idle_cycle();
    chk("hold_no_retire", bus.pc, 32'hBFC0_0004);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("seq_pc2", bus.pc, 32'hBFC0_0008);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("seq_pc3", bus.pc, 32'hBFC0_000C);
    chk("seq_halted", 32'(bus.halted), 32'h0);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("seq_pc4", bus.pc, 32'hBFC0_0010);

    // BEQ taken: target = BFC00014 + 3*4
    retire_op(IC_BEQ, 1'b1, 16'h0003, 26'h0, 32'h0);
    chk("beq_slot_pc", bus.pc, 32'hBFC0_0014);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("beq_target_pc", bus.pc, 32'hBFC0_0020);

    // JR back to BFC00010, then BNE not taken
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'hBFC0_0010);
    chk("jr_slot_pc", bus.pc, 32'hBFC0_0024);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("jr_target_pc", bus.pc, 32'hBFC0_0010);
    retire_op(IC_BNE, 1'b1, 16'h0003, 26'h0, 32'h0);
    chk("bne_slot_pc", bus.pc, 32'hBFC0_0014);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("bne_not_taken_pc", bus.pc, 32'hBFC0_0018);

    // JAL at BFC00040 with index 0x100
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'hBFC0_0040);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("jal_start_pc", bus.pc, 32'hBFC0_0040);
    set_op(IC_JAL, 1'b0, 16'h0, 26'h0000100, 32'h0);
    #1;
    chk("jal_link_we", 32'(bus.link_we), 32'h1);
    chk("jal_link_addr", bus.link_addr, 32'hBFC0_0048);
    do_retire();
    chk("jal_slot_pc", bus.pc, 32'hBFC0_0044);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("jal_target_pc", bus.pc, 32'hB000_0400);

    // BEQ to A=B0000444, delay-slot J to B0000800 must be ignored
    retire_op(IC_BEQ, 1'b1, 16'h0010, 26'h0, 32'h0);
    chk("dslot_beq_pc", bus.pc, 32'hB000_0404);
    retire_op(IC_J, 1'b0, 16'h0, 26'h0000200, 32'h0);
    chk("dslot_first_wins", bus.pc, 32'hB000_0444);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("dslot_second_dropped", bus.pc, 32'hB000_0448);

    // Misaligned JR: not taken, sticky error
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'hBFC0_0080);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("mis_start_pc", bus.pc, 32'hBFC0_0080);
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'hBFC0_0102);
    chk("mis_addr_error", 32'(bus.addr_error), 32'h1);
    chk("mis_pc1", bus.pc, 32'hBFC0_0084);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("mis_pc2_seq", bus.pc, 32'hBFC0_0088);
    chk("mis_error_sticky", 32'(bus.addr_error), 32'h1);

    // Reset while a branch is pending in the delay slot
    retire_op(IC_BEQ, 1'b1, 16'h0040, 26'h0, 32'h0);
    chk("rst_slot_pc", bus.pc, 32'hBFC0_008C);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_mid_pc", bus.pc, 32'hBFC0_0000);
    chk("rst_mid_addr_error", 32'(bus.addr_error), 32'h0);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("rst_pending_cleared", bus.pc, 32'hBFC0_0004);

    // Halt via JR 0 at BFC00080
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'hBFC0_0080);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("halt_start_pc", bus.pc, 32'hBFC0_0080);
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'h0000_0000);
    chk("halt_slot_pc", bus.pc, 32'hBFC0_0084);
    chk("halt_slot_not_halted", 32'(bus.halted), 32'h0);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("halt_pc", bus.pc, 32'h0000_0000);
    idle_cycle();
    chk("halt_flag", 32'(bus.halted), 32'h1);
    retire_op(IC_JR, 1'b0, 16'h0, 26'h0, 32'hBFC0_0000);
    retire_op(IC_ADDU, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("halt_pc_holds", bus.pc, 32'h0000_0000);
    chk("halt_flag_holds", 32'(bus.halted), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised program-counter sequencer for the multicycle MIPS core.
- Holds the architectural PC and resolves branches and jumps, with a one-instruction MIPS delay slot.
- Produces the link address for *AL/JAL/JALR and detects termination when control reaches the halt address.
- Single clock domain: PC updates only on clk, qualified by a one-cycle retire strobe from the control FSM.

Parameters:
ADDR_W, 32, PC/address width (>= 28)
RESET_VECTOR, 32'hBFC00000, PC value after reset
HALT_ADDR, 32'h00000000, jumping here terminates execution
CODE_W, 7, width of decoded internal instruction code

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
retire  in  1  one-cycle strobe: current instruction completes, PC may advance
internal_code  in  CODE_W  decoded opcode of the retiring instruction (package enum)
offset  in  16  branch immediate
instr_index  in  26  J/JAL target field
reg_target  in  ADDR_W  rs value for JR/JALR
zero, positive, negative  in  1 each  ALU compare flags for the retiring instruction (rs vs rt, or rs vs 0)
pc  out  ADDR_W  address of the instruction to fetch/execute
link_we  out  1  retiring instruction writes a link register (combinational on internal_code)
link_addr  out  ADDR_W  pc+8
halted  out  1  execution finished
addr_error  out  1  sticky: misaligned register jump target seen

Behaviour:
- Reset, checked in priority over everything else:
  - pc=RESET_VECTOR; state=RUN; delay_pending=0; target_reg=0; halted=0; addr_error=0.
  - A reset mid-delay-slot discards the pending branch.
- States:
  - RUN: PC advances on retire.
  - HALTED: retire is ignored; pc holds HALT_ADDR; halted=1.
  - Leave HALTED only via reset.
- Target arithmetic, all modulo 2^ADDR_W:
  - Branch target = pc + 4 + (sign-extended offset << 2).
  - J/JAL target = {(pc+4)[ADDR_W-1:28], instr_index, 2'b00}.
  - JR/JALR target = reg_target.
- Taken conditions:
  - BEQ: zero.
  - BNE: !zero.
  - BGTZ: positive.
  - BLEZ: zero|negative.
  - BGEZ/BGEZAL: zero|positive.
  - BLTZ/BLTZAL: negative.
  - J, JAL, JR, JALR: always taken.
- link_we=1 for BGEZAL, BLTZAL, JAL, JALR, regardless of whether the branch is taken.
- On retire in RUN:
  - Next PC: pc <= delay_pending ? target_reg : pc+4.
  - Branch registration:
    - If the retiring instruction is taken AND delay_pending=0: target_reg <= target; delay_pending <= 1.
    - Otherwise: delay_pending <= 0.
  - Branch in a delay slot (delay_pending=1 and taken): the second branch is ignored; the first target wins. No error is flagged.
  - JR/JALR with reg_target[1:0]!=0: treated as not taken; addr_error <= 1 (sticky until reset).
- Halt:
  - When the pc update writes HALT_ADDR, state <= HALTED and halted=1 from the next cycle.
  - The delay-slot instruction has already retired by then.
- No retire: all registers hold.
- Latency:
  - pc changes exactly one cycle after the retire edge.
  - A taken branch redirects on the second retire after it (the delay slot executes).

Decomposition:
- Shared package (mips_pkg): internal code enum, including BEQ=30, BGEZ=31, BGEZAL=32, BGTZ=33, BLEZ=34, BLTZ=35, BLTZAL=36, BNE=37, J=38, JAL=39, JALR=40, JR=41. Also the state enum RUN/HALTED.
- One combinational sub-module, branch_resolve: maps code, flags, offset, index, reg_target and pc to taken, target, link_we and misaligned.
- pc_sequencer keeps the registers and FSM.

Test Plan:
- Reset then 3 retires of ADDU: pc = BFC00000 -> BFC00004 -> BFC00008 -> BFC0000C; halted=0.
- At pc=BFC00010, BEQ zero=1 offset=0x0003, then retire delay slot: pc BFC00014, then BFC00020.
- BNE with zero=1 at BFC00010: not taken; pc BFC00014, BFC00018.
- JAL at BFC00040, instr_index=0x0000100: link_we=1, link_addr=BFC00048; pc BFC00044, then B0000400.
- JR reg_target=0 at BFC00080: pc BFC00084, then 00000000, halted=1 next cycle; further retires leave pc=0.
- JR reg_target=BFC00102: addr_error=1, pc continues BFC00084 sequentially.
- Branch in delay slot: first BEQ to A, delay-slot J to B; pc reaches A, not B.
- Reset asserted during a pending delay slot: pc=BFC00000, delay_pending cleared.
